// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS decode stage with register file, write-back bypass, load-use stall and ID/EX register
module id_stage_hz #(
  parameter int DATA_W    = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W+31:0]  if_id_bundle,
  input  logic                if_id_valid,
  input  logic                flush,
  input  logic                hold,
  input  logic                wb_we,
  input  logic [4:0]          wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [4*DATA_W+23:0] id_ex_bundle,
  output logic                id_ex_valid,
  output logic                illegal_o,
  output logic                stall_o
);
  logic [DATA_W-1:0] rf [32];
  logic [31:0] instr;
  logic [DATA_W-1:0] npc, rd1, rd2, imm;
  logic [5:0] op;
  logic [4:0] rs, rt, rd, ex_rt;
  logic [8:0] ctl;
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_logi, legal, use_rt, wb_hit, ex_mr;
  assign instr   = if_id_bundle[31:0];
  assign npc     = if_id_bundle[DATA_W+31:32];
  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign is_r    = op == 6'h00;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_addi = op == 6'h08;
  assign is_logi = op == 6'h0C || op == 6'h0D;
  assign legal   = is_r | is_lw | is_sw | is_beq | is_addi | is_logi;
  assign use_rt  = is_r | is_sw | is_beq;
  assign ctl = !if_id_valid ? 9'h000 :
               is_r    ? 9'h142 :
               is_lw   ? 9'h08B :
               is_sw   ? 9'h084 :
               is_beq  ? 9'h030 :
               is_addi ? 9'h082 :
               is_logi ? 9'h0E2 : 9'h000;
  assign imm    = is_logi ? DATA_W'(instr[15:0]) : DATA_W'($signed(instr[15:0]));
  assign wb_hit = BYPASS_EN && wb_we && |wb_addr;
  assign rd1    = wb_hit && wb_addr == rs ? wb_data : rf[rs];
  assign rd2    = wb_hit && wb_addr == rt ? wb_data : rf[rt];
  assign ex_mr  = id_ex_bundle[4*DATA_W+18];
  assign ex_rt  = id_ex_bundle[9:5];
  assign stall_o = HAZARD_EN && id_ex_valid && ex_mr && |ex_rt && if_id_valid &&
                   ((legal && ex_rt == rs) || (use_rt && ex_rt == rt));
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      id_ex_bundle <= '0;
      id_ex_valid  <= 1'b0;
      illegal_o    <= 1'b0;
    end else begin
      if (wb_we && |wb_addr) rf[wb_addr] <= wb_data;
      if (flush || (!hold && stall_o)) begin
        id_ex_bundle <= '0;
        id_ex_valid  <= 1'b0;
        illegal_o    <= 1'b0;
      end else if (!hold) begin
        id_ex_bundle <= {ctl, npc, rd1, rd2, imm, rs, rt, rd};
        id_ex_valid  <= if_id_valid;
        illegal_o    <= if_id_valid && !legal;
      end
    end
  end
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: table-driven and directed checks of the decode stage, bypass and hazard logic
module tb_id_stage_hz;
  logic clk = 1'b0, reset = 1'b1;
  logic [63:0] if_id_bundle = '0;
  logic if_id_valid = 1'b0, flush = 1'b0, hold = 1'b0, wb_we = 1'b0;
  logic [4:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [151:0] id_ex_bundle, id_ex_bundle_nb;
  logic id_ex_valid, illegal_o, stall_o, id_ex_valid_nb, illegal_nb, stall_nb;
  int total = 0, passed = 0;
  typedef struct packed {
    logic rst, vld, fl, hd, we;
    logic [4:0] wa;
    logic [31:0] wd, npc, instr;
    logic xs;
    logic [8:0] xc;
    logic [31:0] xn, x1, x2, xi;
    logic [4:0] xrs, xrt, xrd;
    logic xv, xil;
  } vec_t;
  vec_t vecs [20];
  always #5 clk = ~clk;
  id_stage_hz dut (
    .clk(clk), .reset(reset), .if_id_bundle(if_id_bundle), .if_id_valid(if_id_valid),
    .flush(flush), .hold(hold), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_ex_bundle(id_ex_bundle), .id_ex_valid(id_ex_valid), .illegal_o(illegal_o), .stall_o(stall_o)
  );
  id_stage_hz #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .if_id_bundle(if_id_bundle), .if_id_valid(if_id_valid),
    .flush(flush), .hold(hold), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_ex_bundle(id_ex_bundle_nb), .id_ex_valid(id_ex_valid_nb), .illegal_o(illegal_nb), .stall_o(stall_nb)
  );
  task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask
  task automatic drv(input logic r, input logic [31:0] ins, input logic [31:0] pc, input logic v,
                     input logic fl, input logic hd, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    reset = r; if_id_bundle = {pc, ins}; if_id_valid = v; flush = fl; hold = hd;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
  endtask
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [151:0] pk(input vec_t v);
    return {v.xc, v.xn, v.x1, v.x2, v.xi, v.xrs, v.xrt, v.xrd};
  endfunction
  initial begin
    //          rst vld fl hd we wa  wd        npc    instr          xs xc      xn     x1     x2       xi            rs  rt  rd  v  il
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0,        0,     0,             0, 0,      0,     0,     0,       0,            0,  0,  0,  0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 5,  'h11,     0,     0,             0, 0,      0,     0,     0,       0,            0,  0,  0,  0, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 10, 'h22,     0,     0,             0, 0,      0,     0,     0,       0,            0,  0,  0,  0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 0,  0,        0,     'h00AA7820,    0, 'h142,  0,     'h11,  'h22,    'h7820,       5,  10, 15, 1, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 0,  0,        4,     'h8CAA0020,    0, 'h08B,  4,     'h11,  'h22,    'h20,         5,  10, 0,  1, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 0,  0,        8,     'h01451820,    1, 0,      0,     0,     0,       0,            0,  0,  0,  0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 0,  0,        8,     'h01451820,    0, 'h142,  8,     'h22,  'h11,    'h1820,       10, 5,  3,  1, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0,  0,        'hC,   'h30018001,    0, 'h0E2,  'hC,   0,     0,       'h8001,       0,  1,  16, 1, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 0,  0,        'h10,  'h20018001,    0, 'h082,  'h10,  0,     0,       'hFFFF8001,   0,  1,  16, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 1, 6,  'hDEAD,   0,     'h00060020,    0, 'h142,  0,     0,     'hDEAD,  'h20,         0,  6,  0,  1, 0};
    vecs[10] = '{0, 1, 0, 0, 1, 0,  'h55,     0,     'h00000020,    0, 'h142,  0,     0,     0,       'h20,         0,  0,  0,  1, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 0,  0,        0,     'h00000020,    0, 'h142,  0,     0,     0,       'h20,         0,  0,  0,  1, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 0,  0,        'h10,  'hFC000000,    0, 0,      'h10,  0,     0,       0,            0,  0,  0,  1, 1};
    vecs[13] = '{0, 1, 1, 0, 0, 0,  0,        'h14,  'h10220004,    0, 0,      0,     0,     0,       0,            0,  0,  0,  0, 0};
    vecs[14] = '{0, 1, 0, 0, 0, 0,  0,        'h14,  'h10220004,    0, 'h030,  'h14,  0,     0,       4,            1,  2,  0,  1, 0};
    vecs[15] = '{0, 1, 0, 1, 0, 0,  0,        'h18,  'h8CAA0020,    0, 'h030,  'h14,  0,     0,       4,            1,  2,  0,  1, 0};
    vecs[16] = '{0, 1, 0, 1, 0, 0,  0,        'h1C,  'hFC000000,    0, 'h030,  'h14,  0,     0,       4,            1,  2,  0,  1, 0};
    vecs[17] = '{0, 1, 0, 1, 0, 0,  0,        'h20,  'h20018001,    0, 'h030,  'h14,  0,     0,       4,            1,  2,  0,  1, 0};
    vecs[18] = '{1, 1, 0, 1, 0, 0,  0,        'h24,  'h00AA7820,    0, 0,      0,     0,     0,       0,            0,  0,  0,  0, 0};
    vecs[19] = '{0, 1, 0, 0, 0, 0,  0,        0,     'h00AA7820,    0, 'h142,  0,     0,     0,       'h7820,       5,  10, 15, 1, 0};
    for (int i = 0; i < 20; i++) begin
      drv(vecs[i].rst, vecs[i].instr, vecs[i].npc, vecs[i].vld, vecs[i].fl, vecs[i].hd,
          vecs[i].we, vecs[i].wa, vecs[i].wd);
      if (!vecs[i].rst) chk($sformatf("v%0d stall", i), 160'(stall_o), 160'(vecs[i].xs));
      edge_wait();
      chk($sformatf("v%0d bundle", i), 160'(id_ex_bundle), 160'(pk(vecs[i])));
      chk($sformatf("v%0d valid", i), 160'(id_ex_valid), 160'(vecs[i].xv));
      chk($sformatf("v%0d illegal", i), 160'(illegal_o), 160'(vecs[i].xil));
    end
    drv(0, 0, 0, 0, 0, 0, 1, 6, 'h77);
    edge_wait();
    drv(0, 'h00060020, 0, 1, 0, 0, 1, 6, 'h99);
    edge_wait();
    chk("bypass rd2", 160'(id_ex_bundle[78:47]), 160'(32'h99));
    chk("nobypass rd2", 160'(id_ex_bundle_nb[78:47]), 160'(32'h77));
    drv(0, 'h8CAA0020, 4, 1, 0, 0, 0, 0, 0);
    edge_wait();
    for (int k = 0; k < 2; k++) begin
      drv(0, 'h01451820, 8, 1, 0, 1, 0, 0, 0);
      chk($sformatf("hold%0d stall", k), 160'(stall_o), 160'(1));
      edge_wait();
      chk($sformatf("hold%0d ctl", k), 160'(id_ex_bundle[151:143]), 160'(9'h08B));
      chk($sformatf("hold%0d valid", k), 160'(id_ex_valid), 160'(1));
    end
    drv(0, 'h01451820, 8, 1, 0, 0, 0, 0, 0);
    chk("unhold stall", 160'(stall_o), 160'(1));
    edge_wait();
    chk("unhold bubble", 160'(id_ex_bundle), 160'(0));
    chk("unhold valid", 160'(id_ex_valid), 160'(0));
    drv(0, 'h01451820, 8, 1, 0, 0, 0, 0, 0);
    chk("issue stall", 160'(stall_o), 160'(0));
    edge_wait();
    chk("issue ctl", 160'(id_ex_bundle[151:143]), 160'(9'h142));
    chk("issue valid", 160'(id_ex_valid), 160'(1));
    drv(0, 'h8CAA0020, 4, 1, 0, 0, 0, 0, 0);
    edge_wait();
    drv(0, 'h01451820, 8, 1, 1, 0, 0, 0, 0);
    chk("flush+stall stall", 160'(stall_o), 160'(1));
    edge_wait();
    chk("flush+stall valid", 160'(id_ex_valid), 160'(0));
    drv(0, 'h8CAA0020, 4, 1, 0, 0, 0, 0, 0);
    edge_wait();
    drv(0, 'h200A0005, 8, 1, 0, 0, 0, 0, 0);
    chk("addi rt no stall", 160'(stall_o), 160'(0));
    edge_wait();
    chk("addi ctl", 160'(id_ex_bundle[151:143]), 160'(9'h082));
    drv(0, 'h8CAA0020, 4, 1, 0, 0, 0, 0, 0);
    edge_wait();
    drv(0, 'hAC0A0000, 8, 1, 0, 0, 0, 0, 0);
    chk("sw rt stall", 160'(stall_o), 160'(1));
    edge_wait();
    chk("sw bubble valid", 160'(id_ex_valid), 160'(0));
    drv(0, 'hFC000000, 0, 0, 0, 0, 0, 0, 0);
    chk("invalid stall", 160'(stall_o), 160'(0));
    edge_wait();
    chk("invalid illegal", 160'(illegal_o), 160'(0));
    chk("invalid valid", 160'(id_ex_valid), 160'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_stage_hz.md
# id_stage_hz

Parametrised MIPS decode stage with integrated register file, write-back bypass, load-use hazard detection and an ID/EX pipeline register with stall, flush and bubble control. It sits between the IF/ID register and EX. It consumes the IF/ID bundle plus the write-back port and produces a registered ID/EX bundle, a valid bit and a stall request back to fetch. It extends the basic decode stage with an immediate-ALU opcode set, an illegal-opcode flag and pipeline-control behaviour.

## Interface
- DATA_W, 32, datapath, NPC and register width (≥16)
- BYPASS_EN, 1, write-back-to-read forwarding inside the register file
- HAZARD_EN, 1, load-use detection; 0 ties stall_o low
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- if_id_bundle  in  DATA_W+32  {npc[DATA_W-1:0], instr[31:0]}
- if_id_valid  in  1  bundle holds a real instruction
- flush  in  1  branch-taken squash of the instruction being decoded
- hold  in  1  downstream stall; ID/EX register keeps its value
- wb_we  in  1  register write enable
- wb_addr  in  5  write register
- wb_data  in  DATA_W  write data
- id_ex_bundle  out  4*DATA_W+24  {ctl[8:0], npc, rd1, rd2, imm, rs[4:0], rt[4:0], rd[4:0]}, MSB first
- id_ex_valid  out  1  bundle holds a real instruction
- illegal_o  out  1  registered; the decoded opcode was unsupported
- stall_o  out  1  combinational; fetch must hold PC and IF/ID

## Operation
- ctl = {RegDst, ALUSrc, ALUOp[1:0], Branch, MemRead, MemWrite, RegWrite, MemtoReg}.
- Decode by opcode:
  - 0x00 R-type: 1_0_10_0_0_0_1_0
  - 0x23 lw: 0_1_00_0_1_0_1_1
  - 0x2B sw: 0_1_00_0_0_1_0_0
  - 0x04 beq: 0_0_01_1_0_0_0_0
  - 0x08 addi: 0_1_00_0_0_0_1_0
  - 0x0C andi and 0x0D ori: 0_1_11_0_0_0_1_0
  - Any other opcode: ctl all zero; illegal_o=1 when loaded valid.
- imm: zero-extended instr[15:0] for andi/ori; sign-extended to DATA_W for all other opcodes.
- Register file: 32×DATA_W. Register 0 reads 0 and ignores writes. Synchronous write when wb_we=1. Combinational read of instr[25:21] to rd1 and instr[20:16] to rd2.
- Bypass (BYPASS_EN=1): if wb_we=1, wb_addr≠0 and wb_addr equals the read address, the read returns wb_data in the same cycle.
- Load-use hazard: stall_o=1 when HAZARD_EN=1 and all of the following hold:
  - id_ex_valid=1
  - registered MemRead=1
  - registered rt≠0
  - if_id_valid=1
  - registered rt equals a source the current instruction uses:
    - R-type, sw, beq: rs or rt
    - lw, addi, andi, ori: rs only
    - illegal opcodes use no sources.
- ID/EX update priority, evaluated each edge:
  1. reset: all bundle fields 0, id_ex_valid=0, illegal_o=0, every register-file entry 0.
  2. flush: load a bubble.
  3. hold: keep the current contents, including valid and illegal_o.
  4. stall_o=1: load a bubble.
  5. otherwise: load the decode result, with id_ex_valid=if_id_valid.
- Bubble: bundle all zero, id_ex_valid=0, illegal_o=0.
- if_id_valid=0 loads zero ctl, so no illegal flag is raised.
- The register-file write is independent of hold, flush and stall. wb_we is honoured every non-reset cycle.

## Timing
- Decode latency is one cycle: inputs sampled at edge N appear on id_ex_bundle after edge N.
- stall_o depends on current inputs and registered state, with no edge delay. It asserts for exactly one cycle per load-use pair, because the bubble clears MemRead.
- hold and stall together: hold wins and stall_o stays asserted. Fetch remains frozen until hold drops, then the bubble is inserted.
- flush and stall together: a bubble is loaded. stall_o still reflects the hazard, and fetch honours flush priority externally.
- A write and read of the same register in one cycle returns the new data with BYPASS_EN=1 and the old data with BYPASS_EN=0.
- Reset asserted mid-stream clears everything on that edge. The next edge loads normally.

## Test plan
- Reset, then write reg5=0x11, reg10=0x22. Decode add (rs=5, rt=10, rd=15, npc=0) → ctl=0x142, rd1=0x11, rd2=0x22, rd=15, valid=1.
- Decode lw 5,10,0x0020, then next cycle add using rs=10 → stall_o=1 for one cycle. The bubble has valid=0 and ctl=0. The add issues on the following edge.
- Decode andi imm=0x8001 → imm=0x00008001; addi imm=0x8001 → imm=0xFFFF8001.
- Set wb_we=1, wb_addr=6, wb_data=0xDEAD while decoding rt=6 → rd2=0xDEAD with BYPASS_EN=1, and the old value with BYPASS_EN=0. Writing reg0 leaves it reading 0.
- Decode opcode 0x3F → ctl=0, illegal_o=1, valid=1. Next, flush=1 with a valid beq → valid=0, illegal_o=0.
- With hold=1 for three cycles and changing inputs, the bundle stays constant. Reset asserted during hold → all outputs 0 after that edge.
